uart_rx_os: RTL
===============

Name: uart_rx_os

Overview:
- 16x-oversampling UART receiver.
- Sits directly upstream of the single-clock byte FIFO in the UART echo/loader path.
- Its `done` pulse drives FIFO `wen` and `data` drives FIFO `data_in`.
- Improves on single-sample reception: synchronises RXD, validates the start bit, majority-votes every bit, and flags framing errors instead of pushing bad bytes.

Parameters:
- DATA_BITS, 8, payload bits per frame, LSB first.
- CLK_FREQ, 100000000, clock frequency in Hz.
- BAUD, 115200, line rate.
- OVERSAMPLE, 16, samples per bit; fixed at 16 for this revision.
- TICK_DIV, CLK_FREQ/(BAUD*OVERSAMPLE) = 54, clocks per sample tick (localparam).

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- isRx  input  1  receive enable.
- RXD  input  1  asynchronous serial line, idle high.
- data  output  DATA_BITS  last good byte.
- done  output  1  one-cycle pulse: data valid (FIFO wen).
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 without the macro).
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (reset=0, async) values:
  - data=0, done=0, frame_err=0, parity_err=0, busy=0.
  - Synchroniser flops = 1; state = IDLE; counters = 0.
- RXD passes through a 2-FF synchroniser; all logic uses the synchronised copy `rxs`. Falling edge = previous rxs 1, current rxs 0.
- Tick generator: counts 0..TICK_DIV-1 and emits a 1-cycle tick on terminal count. It is cleared to 0 on the start-edge cycle, so sample phase aligns to the edge.
- Sample counter s (0..15) advances per tick. Bit counter b (0..DATA_BITS-1).
- States:
  - IDLE: busy=0. If isRx=1 and a falling edge is seen, go to START and clear tick/s. If isRx=0, edges are ignored.
  - START: capture rxs on ticks s=7,8,9; vote at s=9. Majority 1 means a glitch: return to IDLE, no pulse. Otherwise continue; on s=15 tick go to DATA with b=0.
  - DATA: vote samples 7,8,9 and shift the voted bit into the MSB of the shift register (right shift, LSB first). On s=15 tick, b++. After b=DATA_BITS-1 completes, go to PARITY (macro on) or STOP.
  - STOP: vote at s=9.
    - Voted 1: next cycle data <= shift register and done=1 for 1 cycle (unless parity failed, see below).
    - Voted 0: frame_err=1 for 1 cycle; data unchanged.
    - Either way, return to IDLE at the s=9 tick. This allows a back-to-back start edge within the same stop bit.
- busy=1 in START/DATA/PARITY/STOP.
- isRx falling to 0 mid-frame: abort to IDLE on the next cycle, no pulses, data unchanged.
- Async reset mid-frame: immediate reset values. The next frame is received normally once the line is idle high.
- Latency from synchronised start edge to done (defaults, no parity): (1+8)*16+10 ticks = 154 ticks ≈ 8316 clocks, ±TICK_DIV, plus 2 synchroniser cycles.
- done, frame_err and parity_err are mutually exclusive per frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and votes the parity bit at s=9. Even parity: XOR of data bits and parity bit must be 0.
  - On mismatch, the STOP state emits parity_err instead of done; data unchanged. frame_err takes priority if the stop bit is also bad.
  - Frame = 11 bit periods.
- Undefined: no PARITY state, parity_err tied 0, frame = 10 bit periods.

Decomposition:
- Package uart_pkg:
  - State encoding constants IDLE/START/DATA/PARITY/STOP.
  - Mid-bit sample indices (7,8,9) and OVERSAMPLE.
  - Default CLK_FREQ/BAUD.
- Sub-module uart_os_tick: oversample tick divider with synchronous clear input. Reusable by the transmitter side.

Test Plan:
- Frame 0xA5 at 115200 baud (8.68 us/bit), isRx=1 -> exactly one done pulse; data=0xA5 about 8316 clocks after the edge; frame_err=0.
- 2 us low glitch on idle RXD -> START aborts at s=9; no done/frame_err; busy returns to 0.
- Frame 0x3C with stop bit driven low -> frame_err pulses once; no done; data keeps previous value. Then 0x5A -> done, data=0x5A.
- Back-to-back 0x00 then 0xFF with no idle gap, and sender baud offset by +2% -> two done pulses with data 0x00 then 0xFF.
- reset=0 asserted during bit 4 of 0x81 -> all outputs 0 immediately. After release, frame 0x7E -> done, data=0x7E.
- isRx=0 during frame 0x11 -> no pulses. With UART_RX_PARITY_EN: 0x07 sent with parity 0 -> parity_err pulse and no done; 0x07 with parity 1 -> done, data=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the oversampling UART receiver/transmitter pair.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned OVERSAMPLE   = 16;
  localparam int unsigned DEF_CLK_FREQ = 100_000_000;
  localparam int unsigned DEF_BAUD     = 115_200;

  // Mid-bit sample indices used for the three-way vote
  localparam logic [3:0] SAMPLE_A    = 4'd7;
  localparam logic [3:0] SAMPLE_B    = 4'd8;
  localparam logic [3:0] SAMPLE_C    = 4'd9;
  localparam logic [3:0] SAMPLE_LAST = 4'd15;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick divider: one-cycle tick every TICK_DIV clocks, synchronous clear re-phases it.
module uart_os_tick #(
  parameter int unsigned TICK_DIV = 54
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CntLast = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    tick_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      cnt_d  = '0;
      tick_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver with start validation, 3-sample voting and framing check.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
  parameter int unsigned BAUD      = DEF_BAUD
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  input  logic                 isRx,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] data,
  output logic                 done,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int unsigned TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] BitLast = BW'(DATA_BITS - 1);

  logic rx_meta_q, rxs_q, rxs_prev_q;
  uart_state_e state_q, state_d;
  logic [3:0] s_q, s_d;
  logic [BW-1:0] b_q, b_d;
  logic [1:0] votes_q, votes_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic done_q, done_d, ferr_q, ferr_d;
  logic tick, start_edge, voted, at_mid, at_end;
`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d, perr_q, perr_d;
`endif

  assign start_edge = (state_q == IDLE) & isRx & rxs_prev_q & ~rxs_q;
  assign voted      = majority3(votes_q[0], votes_q[1], rxs_q);
  assign at_mid     = tick & (s_q == SAMPLE_C);
  assign at_end     = tick & (s_q == SAMPLE_LAST);

  uart_os_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk_i (CLK100MHZ),
    .rst_ni(reset),
    .clr_i (start_edge),
    .tick_o(tick)
  );

  always_comb begin
    state_d = state_q;
    s_d     = tick ? s_q + 4'd1 : s_q;
    b_d     = b_q;
    votes_d = votes_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    if (tick && s_q == SAMPLE_A) votes_d[0] = rxs_q;
    if (tick && s_q == SAMPLE_B) votes_d[1] = rxs_q;

    unique case (state_q)
      IDLE: begin
        s_d = '0;
        if (start_edge) state_d = START;
      end
      START: begin
        // A start bit that votes high was only a glitch on the idle line
        if (at_mid && voted) state_d = IDLE;
        else if (at_end) begin
          state_d = DATA;
          b_d     = '0;
        end
      end
      DATA: begin
        if (at_mid) shift_d = {voted, shift_q[DATA_BITS-1:1]};
        if (at_end) begin
          if (b_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            b_d = b_q + BW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (at_mid) par_bad_d = (^shift_q) ^ voted;
        if (at_end) state_d = STOP;
      end
`endif
      STOP: begin
        // Leave at mid-stop so a start edge right after the stop bit is caught
        if (at_mid) begin
          state_d = IDLE;
          if (!voted) ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (par_bad_q) perr_d = 1'b1;
`endif
          else begin
            done_d = 1'b1;
            data_d = shift_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && !isRx) begin
      state_d = IDLE;
      data_d  = data_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= IDLE;
      s_q        <= '0;
      b_q        <= '0;
      votes_q    <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= RXD;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
      state_q    <= state_d;
      s_q        <= s_d;
      b_q        <= b_d;
      votes_q    <= votes_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= par_bad_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign data      = data_q;
  assign done      = done_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
